// File: rtl/mod_counter_cascade.sv
// mod_counter_cascade
// Cascaded modulo counter: DIGITS stages of WIDTH bits. Each stage's enable
// ripples through the terminal counts of the stages below it. Digits
// 0..DIGITS-2 wrap at MAX and the top digit wraps at TOP_MAX. The block also
// provides a parallel load with clamping, a combinational chaining carry and
// a registered wrap pulse.
//
// Optional feature macro: COUNTER_DOWN_EN
//   When defined, dir selects down counting (dir=1) and down terminal values.
//   When undefined, the block counts up only and dir is ignored.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   carry_in    count enable for digit 0 (one step per cycle)
//   dir         0 = up, 1 = down (functional only with COUNTER_DOWN_EN)
//   load        parallel load strobe; takes priority over carry_in
//   load_value  value to load, digit i in bits [i*WIDTH +: WIDTH]
//   value       registered count, same packing as load_value
//   digit_tc    combinational; bit i set when digit i is at its terminal value
//   carry_out   combinational; carry_in & ~load & all digits terminal
//   wrap        registered one-cycle pulse after the whole counter rolled over
//   load_err    registered sticky flag: last load had an out-of-range digit
module mod_counter_cascade #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned MAX     = 9,
  parameter int unsigned TOP_MAX = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    carry_in,
  input  logic                    dir,
  input  logic                    load,
  input  logic [DIGITS*WIDTH-1:0] load_value,
  output logic [DIGITS*WIDTH-1:0] value,
  output logic [DIGITS-1:0]       digit_tc,
  output logic                    carry_out,
  output logic                    wrap,
  output logic                    load_err
);

  localparam int unsigned VW = DIGITS * WIDTH;

  logic [DIGITS-1:0] en;
  logic [VW-1:0]     value_nxt;
  logic              err_nxt;

  // Wrap value of digit i: the top digit uses TOP_MAX, all others MAX.
  function automatic logic [WIDTH-1:0] digit_max(input int unsigned i);
    return (i == DIGITS - 1) ? WIDTH'(TOP_MAX) : WIDTH'(MAX);
  endfunction

`ifndef COUNTER_DOWN_EN
  // dir is kept on the port list for compatibility but has no function here.
  logic unused_dir;
  assign unused_dir = dir;
`endif

  // Terminal-count detection per digit and the ripple enable chain.
  always_comb begin
    digit_tc = '0;
    en       = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
`ifdef COUNTER_DOWN_EN
      if (dir) digit_tc[i] = (value[i*WIDTH +: WIDTH] == '0);
      else     digit_tc[i] = (value[i*WIDTH +: WIDTH] == digit_max(i));
`else
      digit_tc[i] = (value[i*WIDTH +: WIDTH] == digit_max(i));
`endif
    end
    en[0] = carry_in;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      en[i] = en[i-1] & digit_tc[i-1];
    end
  end

  assign carry_out = carry_in & ~load & (&digit_tc);

  // Next-state: load (with per-digit clamp) wins over counting.
  always_comb begin
    value_nxt = value;
    err_nxt   = load_err;
    if (load) begin
      err_nxt = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (load_value[i*WIDTH +: WIDTH] > digit_max(i)) begin
          value_nxt[i*WIDTH +: WIDTH] = digit_max(i);
          err_nxt                     = 1'b1;
        end else begin
          value_nxt[i*WIDTH +: WIDTH] = load_value[i*WIDTH +: WIDTH];
        end
      end
    end else begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (en[i]) begin
`ifdef COUNTER_DOWN_EN
          if (dir) begin
            value_nxt[i*WIDTH +: WIDTH] = (value[i*WIDTH +: WIDTH] == '0)
                                        ? digit_max(i)
                                        : value[i*WIDTH +: WIDTH] - WIDTH'(1);
          end else begin
            value_nxt[i*WIDTH +: WIDTH] = (value[i*WIDTH +: WIDTH] == digit_max(i))
                                        ? '0
                                        : value[i*WIDTH +: WIDTH] + WIDTH'(1);
          end
`else
          value_nxt[i*WIDTH +: WIDTH] = (value[i*WIDTH +: WIDTH] == digit_max(i))
                                      ? '0
                                      : value[i*WIDTH +: WIDTH] + WIDTH'(1);
`endif
        end
      end
    end
  end

  // Digit registers, wrap pulse and sticky load error.
  always_ff @(posedge clk) begin
    if (reset) begin
      value    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      value    <= value_nxt;
      wrap     <= carry_out;
      load_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mod_counter_cascade.sv
// Testbench for mod_counter_cascade (WIDTH=4, DIGITS=2, MAX=9, TOP_MAX=2).
// Reference: the count is an integer 0..29 stepped modulo 30.
module tb_mod_counter_cascade;

  logic       clk = 1'b0;
  logic       reset;
  logic       carry_in;
  logic       dir;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] value;
  logic [1:0] digit_tc;
  logic       carry_out;
  logic       wrap;
  logic       load_err;

  mod_counter_cascade #(
    .WIDTH  (4),
    .DIGITS (2),
    .MAX    (9),
    .TOP_MAX(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .carry_in  (carry_in),
    .dir       (dir),
    .load      (load),
    .load_value(load_value),
    .value     (value),
    .digit_tc  (digit_tc),
    .carry_out (carry_out),
    .wrap      (wrap),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] v;
    logic       w;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   n        = 0;
  logic m_err    = 1'b0;
  bit   model_ok = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] enc(input int x);
    return 8'((x / 10) * 16 + (x % 10));
  endfunction

  // One clock cycle: drive, check combinational outputs, predict, then check registers.
  task automatic cycle(input logic rst, input logic ci, input logic ld,
                       input logic dr, input logic [7:0] lv);
    int   d0, d1, l0, l1;
    logic down, tc0, tc1, co;
    exp_t e;
    reset = rst; carry_in = ci; load = ld; dir = dr; load_value = lv;
    #1;
`ifdef COUNTER_DOWN_EN
    down = dr;
`else
    down = 1'b0;
`endif
    d0  = n % 10;
    d1  = n / 10;
    tc0 = down ? (d0 == 0) : (d0 == 9);
    tc1 = down ? (d1 == 0) : (d1 == 2);
    co  = ci & ~ld & tc0 & tc1;
    if (model_ok) begin
      chk("digit_tc", 32'(digit_tc), 32'({tc1, tc0}));
      chk("carry_out", 32'(carry_out), 32'(co));
    end
    if (rst) begin
      n = 0; m_err = 1'b0; e.w = 1'b0; model_ok = 1'b1;
    end else begin
      e.w = co;
      if (ld) begin
        l0 = int'(lv[3:0]);
        l1 = int'(lv[7:4]);
        m_err = 1'b0;
        if (l0 > 9) begin l0 = 9; m_err = 1'b1; end
        if (l1 > 2) begin l1 = 2; m_err = 1'b1; end
        n = l1 * 10 + l0;
      end else if (ci) begin
        n = down ? (n + 29) % 30 : (n + 1) % 30;
      end
    end
    e.v = enc(n);
    e.e = m_err;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 32'(1), 32'(0));
    end else begin
      e = q.pop_front();
      chk("value", 32'(value), 32'(e.v));
      chk("wrap", 32'(wrap), 32'(e.w));
      chk("load_err", 32'(load_err), 32'(e.e));
    end
  endtask

  initial begin
    reset = 1'b1; carry_in = 1'b0; dir = 1'b0; load = 1'b0; load_value = 8'h00;
    @(posedge clk);
    #1;
    cycle(1, 0, 0, 0, 8'h00);
    cycle(1, 1, 1, 0, 8'h15);

    // Full up sweep 00..29 and rollover to 00 with wrap pulse.
    repeat (30) cycle(0, 1, 0, 0, 8'h00);
    cycle(0, 0, 0, 0, 8'h00);
    cycle(0, 0, 0, 0, 8'h00);

    // Gated counting across the digit-0 terminal.
    cycle(0, 0, 1, 0, 8'h08);
    cycle(0, 1, 0, 0, 8'h00);
    cycle(0, 0, 0, 0, 8'h00);
    cycle(0, 1, 0, 0, 8'h00);

    // Load clamping and sticky error.
    cycle(0, 0, 1, 0, 8'h3C);
    cycle(0, 0, 0, 0, 8'h00);
    cycle(0, 0, 1, 0, 8'h15);
    cycle(0, 0, 1, 0, 8'h39);
    cycle(0, 1, 0, 0, 8'h00);
    cycle(0, 0, 1, 0, 8'h0F);

    // Load has priority over carry_in, even at the terminal value.
    cycle(0, 0, 1, 0, 8'h07);
    cycle(0, 1, 1, 0, 8'h20);
    cycle(0, 0, 1, 0, 8'h29);
    cycle(0, 1, 1, 0, 8'h11);

`ifdef COUNTER_DOWN_EN
    // Down counting from 00 wraps to 29, then reset wins mid-count.
    cycle(0, 0, 1, 1, 8'h00);
    cycle(0, 1, 0, 1, 8'h00);
    cycle(0, 1, 0, 1, 8'h00);
    cycle(0, 1, 0, 1, 8'h00);
    cycle(1, 1, 0, 1, 8'h00);
    cycle(0, 0, 0, 1, 8'h00);
    cycle(0, 1, 0, 0, 8'h00);
    cycle(0, 1, 0, 1, 8'h00);
`else
    // dir is ignored in the up-only build.
    cycle(0, 0, 1, 1, 8'h05);
    cycle(0, 1, 0, 1, 8'h00);
    cycle(0, 1, 0, 1, 8'h00);
    cycle(0, 0, 1, 1, 8'h29);
    cycle(0, 1, 0, 1, 8'h00);
`endif

    // Mixed random traffic against the modulo-30 reference.
    for (int i = 0; i < 60; i++) begin
      cycle(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
